hilo_div_ctrl: RTL and testbench
================================

// Module: hilo_div_ctrl
// PURPOSE
//  Sequencer and owner of the HI/LO registers for the MIPS multi-cycle divider.
//  Accepts DIV/DIVU/MTHI/MTLO ops from the decode stage and launches the iterative divider.
//  Writes quotient to LO and remainder to HI.
//  Stalls MFHI/MFLO reads and new ops while a divide is in flight.
// PARAMETERS
//  W         32  operand/result width
//  MAX_WAIT  40  cycles in WAIT before declaring divider timeout
// PORTS
//  clk          in   1  clock, rising edge
//  rst          in   1  asynchronous reset, active-low
//  op_valid     in   1  op request
//  op_ready     out  1  op accepted when op_valid & op_ready
//  op_code      in   2  0=DIV 1=DIVU 2=MTHI 3=MTLO
//  op_a         in   W  dividend / MTxx data
//  op_b         in   W  divisor
//  rd_req       in   1  MFHI/MFLO read request
//  rd_sel       in   1  0=LO 1=HI
//  rd_data      out  W  selected HI/LO, combinational
//  stall        out  1  rd_req & busy
//  hi, lo       out  W  architectural HI/LO
//  div_a,div_b  out  W  operands to divider, held stable from accept until done
//  div_signed   out  1  1 for DIV
//  div_start    out  1  one-cycle pulse, also serves as divider reset
//  div_done     in   1  divider completion
//  div_q,div_r  in   W  divider results
//  timeout_err  out  1  sticky: divider failed to finish
// BEHAVIOUR
//  Reset: state=IDLE, hi=lo=0, div_a=div_b=0, div_signed=0, div_start=0, timeout_err=0, op_ready=1.
//  Reset mid-op aborts the divide; divider results arriving later are ignored.
//  States: IDLE -> LAUNCH -> WAIT -> IDLE. busy = (state!=IDLE). op_ready = !busy.
//  IDLE:
//   - Accept MTHI/MTLO: hi/lo <= op_a at that edge.
//   - Accept DIV/DIVU with op_b!=0: latch div_a/div_b/div_signed; -> LAUNCH.
//   - Accept DIV/DIVU with op_b==0: no launch, lo<=all-ones, hi<=op_a at accept edge; stay IDLE.
//  LAUNCH: div_start=1 for exactly this cycle; div_done ignored; wait counter cleared; -> WAIT.
//  WAIT:
//   - On div_done=1 sampled: lo<=div_q, hi<=div_r; -> IDLE. op_ready is high the next cycle.
//   - After MAX_WAIT cycles without div_done: timeout_err<=1, hi/lo unchanged; -> IDLE.
//  Latency: accept at edge 0; div_start high cycle 1; results visible the cycle after done is sampled.
//  Simultaneous events:
//   - op_valid while busy: not accepted, no side effects.
//   - rd_req in the completion cycle: stall=1; rd_data shows new value next cycle.
//  Signed divide: quotient truncates toward zero; remainder has dividend sign (divider's job).
//   0x80000000 / -1 is passed through unchanged.
//  rd_data reflects hi/lo even while stalled; consumer must honour stall.
// CONFIGURATION
//  HILO_DIV_FASTPATH_EN defined:
//   - DIVU with op_a<op_b, or any DIV/DIVU with op_b==1, completes at the accept edge.
//     op_a<op_b: lo=0, hi=op_a. op_b==1: lo=op_a, hi=0.
//   - No launch; state stays IDLE.
//  Undefined: these cases use the full LAUNCH/WAIT sequence.
// TESTING
//  1. DIVU a=0xF0000000 b=0x10000000, model done at 34 cycles -> lo=0xF, hi=0; rd_req during WAIT gives stall=1.
//  2. DIV a=-7 b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; div_signed=1 and div_start a single pulse.
//  3. DIVU a=0x1234 b=0 -> next cycle lo=0xFFFFFFFF, hi=0x1234; div_start never asserted; op_ready stays 1.
//  4. MTHI 0xDEAD presented during WAIT -> op_ready=0 until done; accepted after done, hi=0xDEAD.
//  5. Reset pulse mid-WAIT, then div_done -> hi=lo=0, stall=0, op_ready=1, no update from late done.
//  6. div_done held 0 -> timeout_err=1 after MAX_WAIT(40) cycles; hi/lo unchanged; then MTLO 5 gives lo=5.
//     With FASTPATH_EN: DIVU 3/7 -> lo=0, hi=3 in one cycle.

Source files
------------

// File: rtl/hilo_div_ctrl_if.sv
// ----------------------------------------------------------------------------
// hilo_div_ctrl_if
//   Decode-side bus of the HI/LO divide sequencer: op request handshake
//   (op_valid/op_ready with op_code, op_a, op_b) and the MFHI/MFLO read path
//   (rd_req/rd_sel in, rd_data/stall out).
//   modport master : decode stage (drives ops and read requests)
//   modport slave  : hilo_div_ctrl
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
interface hilo_div_ctrl_if #(
    parameter int W = 32
);
    logic         op_valid;
    logic         op_ready;
    logic [1:0]   op_code;    // 0=DIV 1=DIVU 2=MTHI 3=MTLO
    logic [W-1:0] op_a;
    logic [W-1:0] op_b;
    logic         rd_req;
    logic         rd_sel;     // 0=LO 1=HI
    logic [W-1:0] rd_data;
    logic         stall;

    modport master (
        output op_valid, op_code, op_a, op_b, rd_req, rd_sel,
        input  op_ready, rd_data, stall
    );

    modport slave (
        input  op_valid, op_code, op_a, op_b, rd_req, rd_sel,
        output op_ready, rd_data, stall
    );
endinterface

// File: rtl/hilo_div_ctrl.sv
// ----------------------------------------------------------------------------
// hilo_div_ctrl
//   Sequencer and owner of the MIPS HI/LO registers for a multi-cycle
//   iterative divider. Accepts DIV/DIVU/MTHI/MTLO from decode, launches the
//   divider, writes quotient to LO and remainder to HI, and stalls MFHI/MFLO
//   reads while a divide is in flight.
//
// Ports
//   clk          clock, rising edge
//   rst          asynchronous reset, active-low
//   bus          hilo_div_ctrl_if.slave: op handshake + read path
//   hi, lo       architectural HI/LO
//   div_a/div_b  divider operands, stable from accept until completion
//   div_signed   1 for DIV
//   div_start    one-cycle launch pulse (also resets the divider)
//   div_done     divider completion, div_q/div_r its results
//   timeout_err  sticky: divider did not finish within MAX_WAIT cycles
//
// Build option
//   HILO_DIV_FASTPATH_EN : DIVU with op_a<op_b, or any divide by 1, completes
//   at the accept edge without launching the divider.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module hilo_div_ctrl #(
    parameter int W        = 32,
    parameter int MAX_WAIT = 40
) (
    input  logic          clk,
    input  logic          rst,
    hilo_div_ctrl_if.slave bus,
    output logic [W-1:0]  hi,
    output logic [W-1:0]  lo,
    output logic [W-1:0]  div_a,
    output logic [W-1:0]  div_b,
    output logic          div_signed,
    output logic          div_start,
    input  logic          div_done,
    input  logic [W-1:0]  div_q,
    input  logic [W-1:0]  div_r,
    output logic          timeout_err
);
    localparam int CNT_W = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_WAIT - 1);

    localparam logic [1:0] OP_DIV  = 2'd0;
    localparam logic [1:0] OP_DIVU = 2'd1;
    localparam logic [1:0] OP_MTHI = 2'd2;
    localparam logic [1:0] OP_MTLO = 2'd3;

    typedef enum logic [1:0] {IDLE, LAUNCH, WAIT} state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  wait_cnt;
    logic              busy, accept, is_div, b_zero;
    logic              fast_hit;
    logic [W-1:0]      fast_lo, fast_hi;

    assign busy         = (state_q != IDLE);
    assign bus.op_ready = !busy;
    assign accept       = bus.op_valid && !busy;
    assign is_div       = (bus.op_code == OP_DIV) || (bus.op_code == OP_DIVU);
    assign b_zero       = (bus.op_b == '0);
    assign bus.stall    = bus.rd_req && busy;
    // Read data is always the current register; the consumer honours stall.
    assign bus.rd_data  = bus.rd_sel ? hi : lo;

`ifdef HILO_DIV_FASTPATH_EN
    // Trivial divides resolved without the divider. Divide-by-zero takes
    // priority and is handled separately, so op_b is nonzero here.
    always_comb begin
        fast_hit = 1'b0;
        fast_lo  = '0;
        fast_hi  = '0;
        if (is_div && !b_zero) begin
            if (bus.op_b == W'(1)) begin
                fast_hit = 1'b1;
                fast_lo  = bus.op_a;
            end else if (bus.op_code == OP_DIVU && bus.op_a < bus.op_b) begin
                fast_hit = 1'b1;
                fast_hi  = bus.op_a;
            end
        end
    end
`else
    assign fast_hit = 1'b0;
    assign fast_lo  = '0;
    assign fast_hi  = '0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        div_start = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (accept && is_div && !b_zero && !fast_hit) state_d = LAUNCH;
            end
            LAUNCH: begin
                div_start = 1'b1;
                state_d   = WAIT;
            end
            WAIT: begin
                if (div_done || wait_cnt == CNT_LAST) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hi          <= '0;
            lo          <= '0;
            div_a       <= '0;
            div_b       <= '0;
            div_signed  <= 1'b0;
            timeout_err <= 1'b0;
            wait_cnt    <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (accept) begin
                        unique case (bus.op_code)
                            OP_MTHI: hi <= bus.op_a;
                            OP_MTLO: lo <= bus.op_a;
                            default: begin
                                if (b_zero) begin
                                    lo <= '1;
                                    hi <= bus.op_a;
                                end else if (fast_hit) begin
                                    lo <= fast_lo;
                                    hi <= fast_hi;
                                end else begin
                                    div_a      <= bus.op_a;
                                    div_b      <= bus.op_b;
                                    div_signed <= (bus.op_code == OP_DIV);
                                end
                            end
                        endcase
                    end
                end
                // div_done is deliberately not looked at while launching.
                LAUNCH: wait_cnt <= '0;
                WAIT: begin
                    if (div_done) begin
                        lo <= div_q;
                        hi <= div_r;
                    end else if (wait_cnt == CNT_LAST) begin
                        timeout_err <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_hilo_div_ctrl.sv
`timescale 1ns/1ps
module tb_hilo_div_ctrl;
    localparam int W   = 32;
    localparam int LAT = 34;

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] hi, lo, div_a, div_b, div_q, div_r;
    logic         div_signed, div_start, div_done, timeout_err;

    hilo_div_ctrl_if #(.W(W)) bus ();

    hilo_div_ctrl #(.W(W), .MAX_WAIT(40)) dut (
        .clk(clk), .rst(rst), .bus(bus),
        .hi(hi), .lo(lo), .div_a(div_a), .div_b(div_b),
        .div_signed(div_signed), .div_start(div_start),
        .div_done(div_done), .div_q(div_q), .div_r(div_r),
        .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    // Divider model: results LAT cycles after the start pulse, computed from
    // the operands seen at start. model_hold suppresses completion.
    int           mcnt = 0;
    logic [W-1:0] mq = '0, mr = '0;
    logic         model_hold = 1'b0;
    initial begin div_done = 1'b0; div_q = '0; div_r = '0; end
    always @(posedge clk) begin
        div_done <= 1'b0;
        if (div_start) begin
            mcnt <= LAT;
            if (div_signed) begin
                mq <= 32'($signed(div_a) / $signed(div_b));
                mr <= 32'($signed(div_a) % $signed(div_b));
            end else begin
                mq <= div_a / div_b;
                mr <= div_a % div_b;
            end
        end else if (mcnt > 0) begin
            mcnt <= mcnt - 1;
            if (mcnt == 1 && !model_hold) begin
                div_done <= 1'b1;
                div_q    <= mq;
                div_r    <= mr;
            end
        end
    end

    int checks = 0;
    int errors = 0;
    int nstart = 0;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        if (div_start) nstart++;
    endtask

    task automatic issue(input logic [1:0] c, input logic [W-1:0] a, input logic [W-1:0] b);
        bus.op_valid = 1'b1;
        bus.op_code  = c;
        bus.op_a     = a;
        bus.op_b     = b;
        for (int i = 0; i < 200 && !bus.op_ready; i++) step();
        if (!bus.op_ready) chk("issue_ready_timeout", {31'd0, bus.op_ready}, 32'd1);
        step();
        bus.op_valid = 1'b0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 200 && !bus.op_ready; i++) step();
        if (!bus.op_ready) chk("idle_timeout", {31'd0, bus.op_ready}, 32'd1);
    endtask

    typedef struct {
        logic [1:0]   code;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] exp_lo;
        logic [W-1:0] exp_hi;
    } vec_t;

    vec_t vecs[10];

    initial begin
        vecs[0] = '{2'd2, 32'h1111_1111, 32'h0,         32'h0000_0000, 32'h1111_1111};
        vecs[1] = '{2'd3, 32'h2222_2222, 32'h0,         32'h2222_2222, 32'h1111_1111};
        vecs[2] = '{2'd1, 32'hF000_0000, 32'h1000_0000, 32'h0000_000F, 32'h0000_0000};
        vecs[3] = '{2'd0, 32'hFFFF_FFF9, 32'h2,         32'hFFFF_FFFD, 32'hFFFF_FFFF};
        vecs[4] = '{2'd1, 32'h0000_1234, 32'h0,         32'hFFFF_FFFF, 32'h0000_1234};
        vecs[5] = '{2'd0, 32'd100,       32'hFFFF_FFF9, 32'hFFFF_FFF2, 32'h0000_0002};
        vecs[6] = '{2'd1, 32'd3,         32'd7,         32'h0000_0000, 32'h0000_0003};
        vecs[7] = '{2'd0, 32'h8000_0000, 32'd1,         32'h8000_0000, 32'h0000_0000};
        vecs[8] = '{2'd0, 32'hFFFF_FF9C, 32'h0,         32'hFFFF_FFFF, 32'hFFFF_FF9C};
        vecs[9] = '{2'd1, 32'hFFFF_FFFF, 32'h10,        32'h0FFF_FFFF, 32'h0000_000F};

        bus.op_valid = 1'b0; bus.op_code = 2'd0; bus.op_a = '0; bus.op_b = '0;
        bus.rd_req = 1'b0; bus.rd_sel = 1'b0;
        rst = 1'b0;
        step(); step();
        // reset state, sampled while reset is held
        chk("rst_op_ready", {31'd0, bus.op_ready}, 32'd1);
        chk("rst_hi", hi, 32'h0);
        chk("rst_lo", lo, 32'h0);
        chk("rst_div_a", div_a, 32'h0);
        chk("rst_div_b", div_b, 32'h0);
        chk("rst_ctl", {28'd0, div_signed, div_start, timeout_err, bus.stall}, 32'h0);
        rst = 1'b1;
        step();

        // table-driven ops
        for (int i = 0; i < 10; i++) begin
            issue(vecs[i].code, vecs[i].a, vecs[i].b);
            wait_idle();
            chk($sformatf("vec%0d_lo", i), lo, vecs[i].exp_lo);
            chk($sformatf("vec%0d_hi", i), hi, vecs[i].exp_hi);
            bus.rd_sel = 1'b1;
            #1;
            chk($sformatf("vec%0d_rd_hi", i), bus.rd_data, vecs[i].exp_hi);
            bus.rd_sel = 1'b0;
            #1;
        end

        // DIVU launch: single start pulse, stall during WAIT and in completion cycle
        begin
            bit seen_done = 1'b0;
            nstart = 0;
            issue(2'd1, 32'hF000_0000, 32'h1000_0000);
            chk("launch_start", {31'd0, div_start}, 32'd1);
            chk("launch_ready", {31'd0, bus.op_ready}, 32'd0);
            chk("launch_div_a", div_a, 32'hF000_0000);
            chk("launch_div_b", div_b, 32'h1000_0000);
            chk("launch_signed", {31'd0, div_signed}, 32'd0);
            step();
            bus.rd_req = 1'b1; bus.rd_sel = 1'b1; #1;
            chk("wait_stall", {31'd0, bus.stall}, 32'd1);
            chk("wait_rd_data_old", bus.rd_data, 32'h0000_000F);
            for (int i = 0; i < 200 && !bus.op_ready; i++) begin
                if (div_done) begin
                    seen_done = 1'b1;
                    chk("done_cycle_stall", {31'd0, bus.stall}, 32'd1);
                end
                step();
            end
            chk("seen_done", {31'd0, seen_done}, 32'd1);
            chk("after_done_stall", {31'd0, bus.stall}, 32'd0);
            chk("after_done_rd", bus.rd_data, 32'h0000_0000);
            chk("after_done_lo", lo, 32'h0000_000F);
            chk("single_start", nstart, 32'd1);
            bus.rd_req = 1'b0;
        end

        // DIV -7/2: div_signed and exactly one start
        nstart = 0;
        issue(2'd0, 32'hFFFF_FFF9, 32'd2);
        step();
        chk("div_signed", {31'd0, div_signed}, 32'd1);
        wait_idle();
        step(); step();
        chk("div_single_start", nstart, 32'd1);
        chk("div_lo", lo, 32'hFFFF_FFFD);

        // divide by zero: no start, ready stays high
        nstart = 0;
        issue(2'd1, 32'h1234, 32'h0);
        chk("dz_ready", {31'd0, bus.op_ready}, 32'd1);
        chk("dz_lo", lo, 32'hFFFF_FFFF);
        chk("dz_hi", hi, 32'h0000_1234);
        step(); step();
        chk("dz_no_start", nstart, 32'd0);

        // MTHI presented while busy: held off, accepted after completion
        issue(2'd1, 32'd100, 32'd10);
        step(); step();
        bus.op_valid = 1'b1; bus.op_code = 2'd2; bus.op_a = 32'hDEAD;
        step(); step();
        chk("busy_ready", {31'd0, bus.op_ready}, 32'd0);
        chk("busy_hi_unchanged", hi, 32'h0000_1234);
        for (int i = 0; i < 200 && !bus.op_ready; i++) step();
        chk("busy_div_lo", lo, 32'd10);
        chk("busy_div_hi", hi, 32'd0);
        step();
        bus.op_valid = 1'b0;
        chk("mthi_after_busy", hi, 32'h0000_DEAD);

        // reset mid-WAIT, then the late done must be ignored
        issue(2'd1, 32'd50, 32'd5);
        for (int i = 0; i < 10; i++) step();
        bus.rd_req = 1'b1;
        rst = 1'b0; #2;
        chk("midrst_hi", hi, 32'h0);
        chk("midrst_lo", lo, 32'h0);
        rst = 1'b1; #1;
        chk("midrst_ready", {31'd0, bus.op_ready}, 32'd1);
        chk("midrst_stall", {31'd0, bus.stall}, 32'd0);
        for (int i = 0; i < 40; i++) step();
        chk("late_done_lo", lo, 32'h0);
        chk("late_done_hi", hi, 32'h0);
        bus.rd_req = 1'b0;

        // timeout
        model_hold = 1'b1;
        issue(2'd3, 32'hAAAA, 32'h0);
        issue(2'd1, 32'd77, 32'd5);
        for (int i = 0; i < 38; i++) step();
        chk("to_not_yet", {30'd0, timeout_err, bus.op_ready}, 32'd0);
        for (int i = 0; i < 10 && !bus.op_ready; i++) step();
        chk("to_ready", {31'd0, bus.op_ready}, 32'd1);
        chk("to_err", {31'd0, timeout_err}, 32'd1);
        chk("to_lo", lo, 32'hAAAA);
        chk("to_hi", hi, 32'h0);
        model_hold = 1'b0;
        for (int i = 0; i < 5; i++) step();
        issue(2'd3, 32'd5, 32'h0);
        chk("to_mtlo", lo, 32'd5);
        chk("to_sticky", {31'd0, timeout_err}, 32'd1);

        // DIVU 3/7: fast path when enabled, full sequence otherwise
        nstart = 0;
        issue(2'd1, 32'd3, 32'd7);
`ifdef HILO_DIV_FASTPATH_EN
        chk("fast_ready", {31'd0, bus.op_ready}, 32'd1);
        chk("fast_lo", lo, 32'd0);
        chk("fast_hi", hi, 32'd3);
        step(); step();
        chk("fast_no_start", nstart, 32'd0);
`else
        wait_idle();
        chk("slow_lo", lo, 32'd0);
        chk("slow_hi", hi, 32'd3);
        chk("slow_start", nstart, 32'd1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
